// File: rtl/keymem_arbiter_pkg.sv
// keymem_arbiter shared types and widths.
// FSM encoding, bus widths and a saturating counter helper.
package keymem_arbiter_pkg;

  localparam int KEY_W    = 256;
  localparam int KEY_ID_W = 32;
  localparam int TIMER_W  = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP,
    S_GAP
  } state_t;

  function automatic logic [TIMER_W-1:0] sat_inc(
    input logic [TIMER_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/keymem_arbiter_if.sv
// Key lookup bus between network paths, the arbiter and keymem.
// slave = arbiter view, master = environment view.
interface keymem_arbiter_if #(
  parameter int NUM_REQ = 4
);
  import keymem_arbiter_pkg::*;

  logic [NUM_REQ-1:0]          req_key_req;
  logic [NUM_REQ*KEY_ID_W-1:0] req_key_id;
  logic [NUM_REQ-1:0]          req_key_ack;
  logic                        req_key_err;
  logic [KEY_W-1:0]            req_key;
  logic                        mem_key_req;
  logic [KEY_ID_W-1:0]         mem_key_id;
  logic                        mem_key_ack;
  logic [KEY_W-1:0]            mem_key;
  logic [TIMER_W-1:0]          timeout_cnt;

  modport slave (
    input  req_key_req, req_key_id,
    input  mem_key_ack, mem_key,
    output req_key_ack, req_key_err, req_key,
    output mem_key_req, mem_key_id, timeout_cnt
  );

  modport master (
    output req_key_req, req_key_id,
    output mem_key_ack, mem_key,
    input  req_key_ack, req_key_err, req_key,
    input  mem_key_req, mem_key_id, timeout_cnt
  );

endinterface

// File: rtl/keymem_arbiter_rr_arbiter.sv
// Combinational round-robin picker for a shared resource.
// Searches upward from last+1 (mod N); returns one-hot grant and index.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  int p;

  // Walk from lowest to highest priority so the nearest requester wins.
  always_comb begin
    gnt = '0;
    idx = '0;
    p   = 0;
    any = |req;
    for (int k = N; k >= 1; k--) begin
      p = (int'(last) + k) % N;
      if (req[p]) begin
        gnt    = '0;
        gnt[p] = 1'b1;
        idx    = IW'(p);
      end
    end
  end

endmodule

// File: rtl/keymem_arbiter.sv
// Serialises key lookups from NUM_REQ network paths onto one keymem port.
// Round-robin grant, bounded wait, one-cycle ack with optional error.
module keymem_arbiter
  import keymem_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input logic             clk156,
  input logic             areset_clk156,
  keymem_arbiter_if.slave bus
);

  localparam int IW = $clog2(NUM_REQ);
  localparam logic [IW-1:0] LAST_RST = IW'(NUM_REQ - 1);
  localparam logic [TIMER_W-1:0] TMO = TIMER_W'(TIMEOUT_CYC);

  state_t               state;
  state_t               state_nxt;
  logic [NUM_REQ-1:0]   gnt_q;
  logic [NUM_REQ-1:0]   arb_gnt;
  logic [IW-1:0]        last_q;
  logic [IW-1:0]        arb_idx;
  logic                 arb_any;
  logic [KEY_ID_W-1:0]  id_q;
  logic [TIMER_W-1:0]   timer_q;
  logic [KEY_W-1:0]     key_q;
  logic                 err_q;
  logic [TIMER_W-1:0]   tmo_cnt_q;
  logic                 expired;

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_rr (
    .req  (bus.req_key_req),
    .last (last_q),
    .gnt  (arb_gnt),
    .idx  (arb_idx),
    .any  (arb_any)
  );

  assign expired = (timer_q == TMO);

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (arb_any) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  if (bus.mem_key_ack || expired) state_nxt = S_RESP;
      S_RESP:  state_nxt = S_GAP;
      S_GAP:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk156 or posedge areset_clk156) begin
    if (areset_clk156) state <= S_IDLE;
    else               state <= state_nxt;
  end

  // A same-cycle ack beats expiry: the answer is taken, no abort counted.
  always_ff @(posedge clk156 or posedge areset_clk156) begin
    if (areset_clk156) begin
      gnt_q     <= '0;
      last_q    <= LAST_RST;
      id_q      <= '0;
      timer_q   <= '0;
      key_q     <= '0;
      err_q     <= 1'b0;
      tmo_cnt_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (arb_any) begin
            gnt_q  <= arb_gnt;
            last_q <= arb_idx;
            id_q   <= bus.req_key_id[int'(arb_idx)*KEY_ID_W +: KEY_ID_W];
          end
        end
        S_ISSUE: timer_q <= '0;
        S_WAIT: begin
          timer_q <= timer_q + 1'b1;
          if (bus.mem_key_ack) begin
            key_q <= bus.mem_key;
            err_q <= 1'b0;
          end else if (expired) begin
            key_q     <= '0;
            err_q     <= 1'b1;
            tmo_cnt_q <= sat_inc(tmo_cnt_q);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.mem_key_req = (state == S_ISSUE);
  assign bus.mem_key_id  = id_q;
  assign bus.req_key_ack = (state == S_RESP) ? gnt_q : '0;
  assign bus.req_key     = key_q;
  assign bus.req_key_err = err_q;
  assign bus.timeout_cnt = tmo_cnt_q;

endmodule
